// File: rtl/key_loader.sv
// key_loader: assembles a KEY_W-bit key from WORD_W-bit beats and holds it
// while the registered reduction stage settles, then flags the reduced key valid.
// Optional build macro KEY_LOADER_PARITY_EN adds the wr_par port and per-beat even-parity checking.
module key_loader #(
   parameter int WORD_W     = 32,
   parameter int KEY_W      = 512,
   parameter int SETTLE_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
`ifdef KEY_LOADER_PARITY_EN
   input  logic              wr_par,
`endif
   input  logic              zeroize,
   input  logic              key_ack,
   output logic [KEY_W-1:0]  key,
   output logic              key_valid,
   output logic              red_valid,
   output logic [3:0]        word_cnt,
   output logic              load_err
);

   localparam int NUM_WORDS = KEY_W / WORD_W;
   localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [3:0]       LAST_WORD  = 4'(NUM_WORDS - 1);
   localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, READY} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt_nxt;
   logic [SET_W-1:0] settle_cnt, settle_nxt;
   logic             err_nxt;
   logic             key_we;
   logic             key_clr;
   logic             accept;
   logic             par_bad;

   // The write port is open only while a load is possible; decoded straight from state.
   assign wr_ready = (state == IDLE) || (state == LOAD);
   assign accept   = wr_valid && wr_ready;

`ifdef KEY_LOADER_PARITY_EN
   // A beat whose data and parity bit disagree is rejected and aborts the load.
   assign par_bad = accept && (^wr_data ^ wr_par);
`else
   assign par_bad = 1'b0;
`endif

   // Next-state logic: zeroize beats everything, a bad-parity beat acts like zeroize.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = word_cnt;
      settle_nxt = settle_cnt;
      err_nxt    = load_err;
      key_we     = 1'b0;
      key_clr    = 1'b0;
      if (zeroize) begin
         state_nxt  = IDLE;
         cnt_nxt    = 4'd0;
         settle_nxt = '0;
         err_nxt    = 1'b0;
         key_clr    = 1'b1;
      end else if (par_bad) begin
         state_nxt  = IDLE;
         cnt_nxt    = 4'd0;
         settle_nxt = '0;
         err_nxt    = 1'b1;
         key_clr    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  key_we    = 1'b1;
                  state_nxt = LOAD;
                  cnt_nxt   = 4'd1;
                  err_nxt   = 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  key_we = 1'b1;
                  if (word_cnt == LAST_WORD) begin
                     state_nxt  = SETTLE;
                     cnt_nxt    = 4'd0;
                     settle_nxt = '0;
                  end else begin
                     cnt_nxt = word_cnt + 4'd1;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_END) begin
                  state_nxt  = READY;
                  settle_nxt = '0;
               end else begin
                  settle_nxt = settle_cnt + 1'b1;
               end
            end
            READY: begin
               if (key_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Control registers; the valid flags are registered copies of the next-state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_cnt   <= 4'd0;
         settle_cnt <= '0;
         load_err   <= 1'b0;
         key_valid  <= 1'b0;
         red_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         word_cnt   <= cnt_nxt;
         settle_cnt <= settle_nxt;
         load_err   <= err_nxt;
         key_valid  <= (state_nxt == SETTLE) || (state_nxt == READY);
         red_valid  <= (state_nxt == READY);
      end
   end

   // Key register: first word lands in the top slice; unwritten slices keep old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key <= '0;
      end else if (key_clr) begin
         key <= '0;
      end else if (key_we) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (32'(word_cnt) == i) key[KEY_W-1-WORD_W*i -: WORD_W] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: randomized loads checked against a
// word-list model of the key and a cycle-count model of the valid flags.
module tb_key_loader;
   localparam int WW = 32;
   localparam int KW = 512;
   localparam int NW = KW / WW;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_par = 1'b0;
   logic          zeroize = 1'b0;
   logic          key_ack = 1'b0;
   logic [WW-1:0] wr_data = '0;
   logic          wr_ready, key_valid, red_valid, load_err;
   logic [KW-1:0] key;
   logic [3:0]    word_cnt;

   int total = 0;
   int bad = 0;
   logic [WW-1:0] words[NW];
   logic [KW-1:0] exp_key;

   key_loader #(.WORD_W(WW), .KEY_W(KW), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
`ifdef KEY_LOADER_PARITY_EN
      .wr_par(wr_par),
`endif
      .zeroize(zeroize), .key_ack(key_ack), .key(key), .key_valid(key_valid),
      .red_valid(red_valid), .word_cnt(word_cnt), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference key: words concatenated in arrival order, first word most significant.
   function automatic logic [KW-1:0] assemble();
      logic [KW-1:0] t = '0;
      for (int i = 0; i < NW; i++) t = (t << WW) | KW'(words[i]);
      return t;
   endfunction

   task automatic randomize_words();
      for (int i = 0; i < NW; i++) words[i] = $urandom;
   endtask

   // mode 0: full rate, 1: valid every other cycle, 2: random gaps plus stray acks
   task automatic load_key(input int mode);
      int n = 0;
      int cyc = 0;
      while (n < NW && cyc < 400) begin
         wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(3) != 0);
         wr_data  = wr_valid ? words[n] : WW'($urandom);
         wr_par   = ^wr_data;
         key_ack  = (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
         tick();
         cyc++;
         if (wr_valid) n++;
         total++;
         if (word_cnt !== 4'(n % NW)) begin
            bad++; $display("FAIL load_word_cnt got=%0d exp=%0d", word_cnt, n % NW);
         end
         total++;
         if (key_valid !== (n == NW)) begin
            bad++; $display("FAIL load_key_valid got=%b exp=%b beats=%0d", key_valid, (n == NW), n);
         end
         total++;
         if (wr_ready !== (n < NW)) begin
            bad++; $display("FAIL load_wr_ready got=%b exp=%b beats=%0d", wr_ready, (n < NW), n);
         end
      end
      wr_valid = 1'b0;
      key_ack  = 1'b0;
      total++;
      if (n < NW) begin
         bad++; $display("FAIL load_timeout got=%0d beats exp=%0d", n, NW);
      end
      exp_key = assemble();
      // c counts cycles since the last beat; red_valid is due at c == S.
      for (int c = 0; c <= S + 1; c++) begin
         total++;
         if (key_valid !== 1'b1) begin
            bad++; $display("FAIL settle_key_valid c=%0d got=%b exp=1", c, key_valid);
         end
         total++;
         if (red_valid !== (c >= S)) begin
            bad++; $display("FAIL settle_red_valid c=%0d got=%b exp=%b", c, red_valid, (c >= S));
         end
         total++;
         if (wr_ready !== 1'b0) begin
            bad++; $display("FAIL settle_wr_ready c=%0d got=%b exp=0", c, wr_ready);
         end
         total++;
         if (key !== exp_key) begin
            bad++; $display("FAIL settle_key c=%0d got=%h exp=%h", c, key, exp_key);
         end
         key_ack  = (mode == 2 && c < S) ? 1'b1 : 1'b0;
         wr_valid = 1'($urandom_range(1));
         wr_data  = WW'($urandom);
         wr_par   = ^wr_data;
         if (c < S + 1) tick();
      end
      key_ack  = 1'b0;
      wr_valid = 1'b0;
   endtask

   task automatic do_ack();
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      total++;
      if (key_valid !== 1'b0 || red_valid !== 1'b0 || wr_ready !== 1'b1) begin
         bad++; $display("FAIL ack_flags got kv=%b rv=%b rdy=%b exp kv=0 rv=0 rdy=1",
                         key_valid, red_valid, wr_ready);
      end
      total++;
      if (key !== exp_key) begin
         bad++; $display("FAIL ack_key_held got=%h exp=%h", key, exp_key);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if (key !== '0) begin bad++; $display("FAIL reset_key got=%h exp=0", key); end
      total++;
      if (key_valid !== 1'b0 || red_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valids got kv=%b rv=%b exp 0 0", key_valid, red_valid);
      end
      total++;
      if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
      total++;
      if (word_cnt !== 4'd0 || load_err !== 1'b0) begin
         bad++; $display("FAIL reset_cnt_err got cnt=%0d err=%b exp 0 0", word_cnt, load_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NW; i++) words[i] = WW'(i);
      load_key(0);
      total++;
      if (key[511:480] !== 32'h0 || key[31:0] !== 32'hF) begin
         bad++; $display("FAIL b2b_slices got top=%h bot=%h exp top=0 bot=f", key[511:480], key[31:0]);
      end
      // Writes offered while READY must be ignored.
      for (int k = 0; k < 5; k++) begin
         wr_valid = 1'b1;
         wr_data  = WW'($urandom);
         wr_par   = ^wr_data;
         tick();
         total++;
         if (key !== exp_key || red_valid !== 1'b1 || wr_ready !== 1'b0 || word_cnt !== 4'd0) begin
            bad++; $display("FAIL ready_hold k=%0d got key=%h rv=%b rdy=%b cnt=%0d exp key=%h rv=1 rdy=0 cnt=0",
                            k, key, red_valid, wr_ready, word_cnt, exp_key);
         end
      end
      wr_valid = 1'b0;
      do_ack();
   endtask

   task automatic test_gaps();
      for (int i = 0; i < NW; i++) words[i] = WW'(i);
      load_key(1);
      do_ack();
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         randomize_words();
         load_key(2);
         do_ack();
      end
   endtask

   task automatic test_zeroize();
      randomize_words();
      for (int i = 0; i < 7; i++) begin
         wr_valid = 1'b1; wr_data = words[i]; wr_par = ^wr_data;
         tick();
      end
      zeroize  = 1'b1;
      wr_valid = 1'b1;
      wr_data  = WW'($urandom);
      wr_par   = ^wr_data;
      tick();
      zeroize  = 1'b0;
      wr_valid = 1'b0;
      total++;
      if (key !== '0 || word_cnt !== 4'd0 || wr_ready !== 1'b1 || key_valid !== 1'b0) begin
         bad++; $display("FAIL zeroize_mid got key=%h cnt=%0d rdy=%b kv=%b exp key=0 cnt=0 rdy=1 kv=0",
                         key, word_cnt, wr_ready, key_valid);
      end
      randomize_words();
      load_key(0);
      key_ack = 1'b1;
      zeroize = 1'b1;
      tick();
      key_ack = 1'b0;
      zeroize = 1'b0;
      total++;
      if (key !== '0 || key_valid !== 1'b0 || red_valid !== 1'b0 || wr_ready !== 1'b1) begin
         bad++; $display("FAIL zeroize_ack got key=%h kv=%b rv=%b rdy=%b exp key=0 kv=0 rv=0 rdy=1",
                         key, key_valid, red_valid, wr_ready);
      end
   endtask

   task automatic test_reset_settle();
      randomize_words();
      for (int i = 0; i < NW; i++) begin
         wr_valid = 1'b1; wr_data = words[i]; wr_par = ^wr_data;
         tick();
      end
      wr_valid = 1'b0;
      total++;
      if (key_valid !== 1'b1 || red_valid !== 1'b0) begin
         bad++; $display("FAIL pre_reset_settle got kv=%b rv=%b exp kv=1 rv=0", key_valid, red_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (key !== '0 || key_valid !== 1'b0 || red_valid !== 1'b0 || wr_ready !== 1'b1 ||
          word_cnt !== 4'd0 || load_err !== 1'b0) begin
         bad++; $display("FAIL async_reset got key=%h kv=%b rv=%b rdy=%b cnt=%0d err=%b exp all reset",
                         key, key_valid, red_valid, wr_ready, word_cnt, load_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

`ifdef KEY_LOADER_PARITY_EN
   task automatic test_parity();
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = WW'($urandom); wr_par = ^wr_data;
         tick();
      end
      wr_data = 32'h0000_0001;
      wr_par  = 1'b0;
      tick();
      wr_valid = 1'b0;
      total++;
      if (load_err !== 1'b1 || key !== '0 || word_cnt !== 4'd0 || wr_ready !== 1'b1) begin
         bad++; $display("FAIL parity_bad got err=%b key=%h cnt=%0d rdy=%b exp err=1 key=0 cnt=0 rdy=1",
                         load_err, key, word_cnt, wr_ready);
      end
      wr_valid = 1'b1; wr_data = WW'($urandom); wr_par = ^wr_data;
      tick();
      wr_valid = 1'b0;
      total++;
      if (load_err !== 1'b0 || word_cnt !== 4'd1) begin
         bad++; $display("FAIL parity_clear got err=%b cnt=%0d exp err=0 cnt=1", load_err, word_cnt);
      end
      zeroize = 1'b1;
      tick();
      zeroize = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_random();
      test_zeroize();
      test_reset_settle();
`ifdef KEY_LOADER_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
